// File: rtl/serial_add_ctrl_if.sv
// Handshake/operand bundle for serial_add_ctrl.
// With SERIAL_ADD_SUB_EN defined, a SUB request bit travels alongside the operands.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADD_SUB_EN
    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout
    );
    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout
    );
`else
    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );
    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared full-adder cell, one bit per clock, LSB first.
// Define SERIAL_ADD_SUB_EN to add a SUB request that computes A-B (Cout=1 means no borrow).
module serial_add_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);
    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    serial_add_ctrl_if.slave  bus
);
    localparam int              CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   op_a_q;
    logic [WIDTH-1:0]   op_b_q;
    logic               carry_q;
    logic [WIDTH-1:0]   psum_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               busy_q;
    logic               done_q;

    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH-1:0]   psum_d;
    logic [WIDTH-1:0]   op_b_d;
    logic               carry_d;

    serial_add_fa u_fa (
        .a_i    (op_a_q[0]),
        .b_i    (op_b_q[0]),
        .cin_i  (carry_q),
        .sum_o  (fa_sum),
        .cout_o (fa_cout)
    );

    // New sum bits enter at the MSB, so after WIDTH shifts bit 0 holds the first result bit.
    assign psum_d = {fa_sum, psum_q[WIDTH-1:1]};

`ifdef SERIAL_ADD_SUB_EN
    // Two's-complement subtract: invert B and force the initial carry to 1.
    assign op_b_d  = bus.sub ? ~bus.b : bus.b;
    assign carry_d = bus.sub ? 1'b1   : bus.cin;
`else
    assign op_b_d  = bus.b;
    assign carry_d = bus.cin;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            psum_q  <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        op_a_q  <= bus.a;
                        op_b_q  <= op_b_d;
                        carry_q <= carry_d;
                        psum_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    op_a_q  <= op_a_q >> 1;
                    op_b_q  <= op_b_q >> 1;
                    carry_q <= fa_cout;
                    psum_q  <= psum_d;
                    if (cnt_q == LAST) begin
                        sum_q   <= psum_d;
                        cout_q  <= fa_cout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                FIN: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed plus randomized checks of serial_add_ctrl against an arithmetic reference model.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SERIAL_ADD_SUB_EN
    logic sub_sel;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [W:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int unsigned r;
        r = int'(a) + int'(b) + int'(c);
        return (W+1)'(r);
    endfunction

    function automatic logic [W:0] model_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        int r;
        r = int'(a) - int'(b);
        if (r < 0) r = r + (1 << W);
        return {(a >= b), W'(r)};
    endfunction

    // Caller sits on a negedge; drives START for one cycle and follows the operation to IDLE.
    // poke >= 0 pulses START with junk operands during that RUN cycle index.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic [W-1:0] exp_sum, input logic exp_cout, input int poke);
        logic [W-1:0] prev_sum;
        logic         prev_cout;
        prev_sum  = bus.sum;
        prev_cout = bus.cout;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = c;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            bus.cin   = 1'($urandom);
            if (i == poke) begin
                bus.start = 1'b1;
                bus.a     = '1;
                bus.b     = '1;
            end
            check("busy_run", 64'(bus.busy), 64'(1));
            check("done_run", 64'(bus.done), 64'(0));
            check("sum_hold", 64'({bus.cout, bus.sum}), 64'({prev_cout, prev_sum}));
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("done_pulse", 64'(bus.done), 64'(1));
        check("busy_fin", 64'(bus.busy), 64'(0));
        check("sum", 64'(bus.sum), 64'(exp_sum));
        check("cout", 64'(bus.cout), 64'(exp_cout));
        $display("op a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d (want %02h/%0d)",
                 a, b, c, bus.sum, bus.cout, exp_sum, exp_cout);
        @(negedge clk);
        check("done_one_cycle", 64'(bus.done), 64'(0));
        check("busy_idle", 64'(bus.busy), 64'(0));
    endtask

    initial begin
        logic [W:0]   exp;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        int           done_k[$];
        logic [W:0]   done_v[$];

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub_sel = 1'b0;
        bus.sub = 1'b0;
`endif
        #1;
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_sum", 64'(bus.sum), 64'(0));
        check("rst_cout", 64'(bus.cout), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(8'h3C, 8'hA5, 1'b0, 8'hE1, 1'b0, -1);
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, -1);
        do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, -1);
        do_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, -1);
        do_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 2);
        check("no_queued_op", 64'(bus.busy), 64'(0));

        // Abort in the 5th RUN cycle; the following op must start from a clean carry.
        bus.start = 1'b1;
        bus.a = 8'hFF;
        bus.b = 8'hFF;
        bus.cin = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_done", 64'(bus.done), 64'(0));
        check("abort_sum", 64'(bus.sum), 64'(0));
        check("abort_cout", 64'(bus.cout), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, -1);

        // START held high: two accepted ops, DONE spaced W+2 cycles.
        bus.start = 1'b1;
        bus.a = 8'h01;
        bus.b = 8'h02;
        bus.cin = 1'b0;
        for (int k = 1; k <= 2*W + 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.a = 8'h80;
                bus.b = 8'h80;
            end
            if (k == W + 3) bus.start = 1'b0;
            if (bus.done) begin
                done_k.push_back(k);
                done_v.push_back({bus.cout, bus.sum});
            end
        end
        check("b2b_count", 64'(done_k.size()), 64'(2));
        if (done_k.size() == 2) begin
            check("b2b_spacing", 64'(done_k[1] - done_k[0]), 64'(W + 2));
            check("b2b_res0", 64'(done_v[0]), 64'({1'b0, 8'h03}));
            check("b2b_res1", 64'(done_v[1]), 64'({1'b1, 8'h00}));
        end
        $display("back-to-back: %0d DONE pulses", done_k.size());

`ifdef SERIAL_ADD_SUB_EN
        bus.sub = 1'b1;
        do_op(8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, -1);
        bus.sub = 1'b1;
        do_op(8'h07, 8'h05, 1'b1, 8'h02, 1'b1, -1);
        bus.sub = 1'b0;
`endif

        for (int n = 0; n < 24; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            sub_sel = 1'($urandom);
            bus.sub = sub_sel;
            exp = sub_sel ? model_sub(ra, rb) : model_add(ra, rb, rc);
`else
            exp = model_add(ra, rb, rc);
`endif
            do_op(ra, rb, rc, exp[W-1:0], exp[W], -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencing controller that performs a WIDTH-bit addition on one shared 1-bit full-adder cell (the existing FA: A, B, Cin -> SUM, Cout). It processes one bit per clock, LSB first.
- Captures operands on a START handshake and keeps the running carry in a register between bits.
- Presents the registered result with a one-cycle DONE pulse.
- Area-saving alternative to a ripple adder; it is the first clocked user of the FA cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- CLK  input  1  rising-edge clock.
- RST_n  input  1  asynchronous active-low reset.
- START  input  1  request to begin an addition; sampled only in IDLE.
- A  input  WIDTH  operand A; captured on the accepting edge.
- B  input  WIDTH  operand B; captured on the accepting edge.
- Cin  input  1  carry-in; captured on the accepting edge.
- BUSY  output  1  high while the bit-serial addition is running.
- DONE  output  1  one-cycle pulse; SUM/Cout are newly valid.
- SUM  output  WIDTH  registered result; held until the next completion.
- Cout  output  1  registered carry-out of the MSB; held with SUM.

Behaviour:
- Reset (RST_n low, asynchronous):
  - State goes to IDLE.
  - BUSY=0, DONE=0, SUM=0, Cout=0.
  - Operand shift registers, carry register and bit counter are all cleared.
- States:
  - IDLE: BUSY=0, DONE=0. START=1 on an edge -> capture A, B, Cin into opA, opB and carry; counter=0; go to RUN. START=0 -> stay in IDLE.
  - RUN: BUSY=1. Each edge:
    - FA is fed opA[0], opB[0] and the carry register.
    - FA SUM is shifted into the MSB of the partial-sum register.
    - FA Cout is loaded into the carry register.
    - opA and opB shift right by one; counter increments.
    - When counter==WIDTH-1: load the partial sum (including this final bit) into SUM, load FA Cout into Cout, go to FIN.
  - FIN: BUSY=0, DONE=1 for exactly one cycle; next edge goes to IDLE unconditionally.
- Latency:
  - START accepted at edge t -> RUN occupies the WIDTH cycles after edge t.
  - SUM/Cout update at edge t+WIDTH; DONE is high during the cycle after edge t+WIDTH.
  - Minimum START-to-START spacing is WIDTH+2 cycles.
- Arithmetic: {Cout, SUM} = A + B + Cin, computed modulo 2^(WIDTH+1), no truncation.
- Boundary conditions:
  - START in RUN or FIN: ignored. Captured operands are not disturbed and no request is queued.
  - START held high continuously: a new operation is accepted in every IDLE cycle, i.e. back-to-back operations with period WIDTH+2.
  - A/B/Cin changing during RUN: no effect.
  - SUM/Cout are stable throughout RUN; they change only at FIN entry or on reset.
  - RST_n asserted mid-RUN: immediate abort to IDLE with all outputs zero. The next operation must not see the stale carry.
  - Counter width is clog2(WIDTH). It must not wrap before WIDTH-1 is reached.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port SUB (1 bit), captured with the operands.
  - SUB=1: opB is loaded as ~B, the carry register is loaded with 1 (Cin ignored), and the result is A-B modulo 2^WIDTH. Cout=1 means no borrow (A>=B).
  - SUB=0: behaviour identical to the non-macro build.
- Undefined: no SUB port; addition only.

Test Plan (WIDTH=8):
- Reset and basic add:
  - Assert RST_n=0 -> BUSY=0, DONE=0, SUM=8'h00, Cout=0.
  - Release reset; START with A=8'h3C, B=8'hA5, Cin=0 -> BUSY high 8 cycles, then DONE pulse of 1 cycle with SUM=8'hE1, Cout=0.
- Carry corners:
  - A=8'hFF, B=8'h01, Cin=0 -> SUM=8'h00, Cout=1.
  - A=8'hFF, B=8'hFF, Cin=1 -> SUM=8'hFF, Cout=1.
  - A=8'h00, B=8'h00, Cin=1 -> SUM=8'h01, Cout=0.
- Busy rejection and stability:
  - START A=8'h10, B=8'h20; pulse START again in the 3rd RUN cycle with A=8'hFF, B=8'hFF.
  - Required: exactly one DONE pulse, SUM=8'h30, Cout=0.
  - SUM holds its previous value throughout RUN.
- Reset mid-operation:
  - START A=8'hFF, B=8'hFF, Cin=1; drop RST_n during the 5th RUN cycle -> outputs 0 immediately.
  - After release, START A=8'h01, B=8'h01, Cin=0 -> SUM=8'h02, Cout=0 (no stale carry).
- Back-to-back:
  - START held high with operand pairs (8'h01, 8'h02) then (8'h80, 8'h80).
  - Required: DONE pulses 10 cycles apart, results 8'h03/Cout=0 then 8'h00/Cout=1.
- SERIAL_ADD_SUB_EN build:
  - SUB=1, A=8'h05, B=8'h07 -> SUM=8'hFE, Cout=0.
  - SUB=1, A=8'h07, B=8'h05 -> SUM=8'h02, Cout=1.
